// File: rtl/irq_ctrl_if.sv
// Request/acknowledge bundle between irq_ctrl (master) and the datapath (slave).
// The controller drives the request, id, vector and status; the datapath returns ack and uret.
interface irq_ctrl_if;
  logic        irq_ack;
  logic        uret;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [31:0] irq_vec;
  logic [2:0]  irq_pending;
  logic [2:0]  in_service;

  modport master (
    input  irq_ack,
    input  uret,
    output irq_req,
    output irq_id,
    output irq_vec,
    output irq_pending,
    output in_service
  );

  modport slave (
    output irq_ack,
    output uret,
    input  irq_req,
    input  irq_id,
    input  irq_vec,
    input  irq_pending,
    input  in_service
  );
endinterface

// File: rtl/irq_ctrl.sv
// Three-source debounced interrupt controller with fixed priority (2 highest).
// Define IRQ_NEST_EN to let a higher-priority source preempt an active handler.
module irq_ctrl #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  key,
  irq_ctrl_if.master  bus
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  rise;
  logic [2:0]  pend_reg, pend_next;
  logic [2:0]  svc_reg, svc_next;
  logic [2:0]  pend_clr, svc_set, svc_ret, svc_after;
  logic [1:0]  id_reg, id_next;
  logic [31:0] vec_reg;
  logic        irq_req_reg;
  logic        load_id;

  function automatic logic [1:0] top_idx(input logic [2:0] v);
    if (v[2])      return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  // Per source: 2-FF synchronizer, stability counter, and a delayed copy
  // of the debounced level so a rising edge lasts exactly one cycle.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src
      logic          sync1_reg, sync2_reg;
      logic          db_reg, db_prev_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          db_reg      <= 1'b0;
          db_prev_reg <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          sync1_reg   <= key[gi];
          sync2_reg   <= sync1_reg;
          db_prev_reg <= db_reg;
          if (sync2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            db_reg  <= ~db_reg;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
      end

      assign rise[gi] = db_reg & ~db_prev_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    load_id    = 1'b0;
    pend_clr   = 3'b000;
    svc_set    = 3'b000;
    svc_ret    = 3'b000;

    // uret with nothing in service is simply dropped
    if (bus.uret && (svc_reg != 3'b000)) begin
      svc_ret = onehot(top_idx(svc_reg));
    end
    svc_after = svc_reg & ~svc_ret;

    case (state_reg)
      S_IDLE: begin
        if (pend_reg != 3'b000) begin
          state_next = S_REQ;
          load_id    = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.irq_ack) begin
          pend_clr   = onehot(id_reg);
          svc_set    = onehot(id_reg);
          state_next = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (svc_after == 3'b000) begin
          state_next = S_IDLE;
        end
`ifdef IRQ_NEST_EN
        else if ((pend_reg != 3'b000) && (top_idx(pend_reg) > top_idx(svc_after))) begin
          state_next = S_REQ;
          load_id    = 1'b1;
        end
`endif
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    svc_next  = svc_after | svc_set;
    // a new edge in the same cycle as the ack clear keeps the bit pending
    pend_next = (pend_reg & ~pend_clr) | rise;
    id_next   = load_id ? top_idx(pend_reg) : id_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      pend_reg    <= 3'b000;
      svc_reg     <= 3'b000;
      id_reg      <= 2'd0;
      vec_reg     <= VEC_BASE;
      irq_req_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      svc_reg     <= svc_next;
      id_reg      <= id_next;
      vec_reg     <= VEC_BASE + {28'd0, id_next, 2'b00};
      irq_req_reg <= (state_next == S_REQ);
    end
  end

  assign bus.irq_req     = irq_req_reg;
  assign bus.irq_id      = id_reg;
  assign bus.irq_vec     = vec_reg;
  assign bus.irq_pending = pend_reg;
  assign bus.in_service  = svc_reg;

endmodule
